column_sync: RTL and testbench

Timestep sequencer and sample collector for the drum mesh. It sits above the array of `build_column` instances, on the far end of their `flag`/`start` handshake. Each timestep it waits until every column reports done, then captures the middle-node displacement from the centre column into a 2-entry sample FIFO. It then broadcasts a one-cycle `start`, and waits for all columns to acknowledge before the next step. Audio-side backpressure throttles the simulation, so samples are never dropped.

---
 rtl/column_sync.sv | 172 +++++++++++++++++
 tb/tb_column_sync.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_sync.sv
// column_sync: timestep sequencer and sample collector for the drum mesh.
// Waits for every column to report done, captures the centre column's
// middle-node value into a 2-entry FIFO, pulses start, then waits for all
// columns to drop their flags before the next step.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | sequencing disabled, waiting for run
// COLLECT | waiting for all flags high and FIFO space
// FIRE    | start pulse cycle
// ACK     | waiting for all flags low, bounded by the ack timeout
// ERR     | ack timeout seen; only reset leaves this state
module column_sync #(
    parameter int NUM_COLS    = 30,
    parameter int DATA_W      = 18,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_COLS-1:0]      flags,
    input  logic signed [DATA_W-1:0] u_mid,
    output logic                     start,
    output logic signed [DATA_W-1:0] sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic [31:0]              step_count,
    output logic [15:0]              step_cycles,
    output logic                     busy,
    output logic                     error
);

    localparam int TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FIRE,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t                     r_state;
    logic                       r_start;
    logic                       r_busy;
    logic                       r_error;
    logic [31:0]                r_step_count;
    logic [15:0]                r_step_cycles;
    logic [15:0]                r_cyc_cnt;
    logic [TO_W-1:0]            r_to_cnt;

    logic [1:0]                 r_count;
    logic                       r_valid;
    logic signed [DATA_W-1:0]   r_head;
    logic signed [DATA_W-1:0]   r_hold;

    logic                       w_all_done;
    logic                       w_all_clear;
    logic                       w_space;
    logic                       w_push;
    logic                       w_pop;

    // Space looks only at the current count; a same-cycle pop does not help.
    assign w_all_done  = &flags;
    assign w_all_clear = ~|flags;
    assign w_space     = (r_count < 2'd2);
    assign w_push      = (r_state == ST_COLLECT) && run && w_all_done && w_space;
    assign w_pop       = r_valid && sample_ready;

    // Step sequencer: one registered FSM driving start, counters and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_step_count  <= 32'd0;
            r_step_cycles <= 16'd0;
            r_cyc_cnt     <= 16'd0;
            r_to_cnt      <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state   <= ST_COLLECT;
                        r_cyc_cnt <= 16'd0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (r_cyc_cnt != 16'hFFFF) begin
                        r_cyc_cnt <= r_cyc_cnt + 16'd1;
                    end
                    if (!run) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_all_done && w_space) begin
                        r_step_cycles <= r_cyc_cnt;
                        r_start       <= 1'b1;
                        r_state       <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    r_state  <= ST_ACK;
                    r_to_cnt <= '0;
                end
                ST_ACK: begin
                    if (w_all_clear) begin
                        r_step_count <= r_step_count + 32'd1;
                        r_cyc_cnt    <= 16'd0;
                        r_state      <= ST_COLLECT;
                    end else if (r_to_cnt == TO_MAX) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry sample FIFO: registered head plus one holding slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push && w_pop) begin
                // Only possible with one entry: the new value replaces the head.
                r_head <= u_mid;
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head  <= u_mid;
                    r_count <= 2'd1;
                    r_valid <= 1'b1;
                end else begin
                    r_hold  <= u_mid;
                    r_count <= 2'd2;
                end
            end else if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head  <= r_hold;
                    r_count <= 2'd1;
                end else begin
                    r_count <= 2'd0;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign start        = r_start;
    assign busy         = r_busy;
    assign error        = r_error;
    assign step_count   = r_step_count;
    assign step_cycles  = r_step_cycles;
    assign sample_data  = r_head;
    assign sample_valid = r_valid;

endmodule

// File: tb/tb_column_sync.sv
// tb_column_sync: directed and randomized steps for column_sync, checked
// against a transaction-level model (phase, sample queue, step counters).
module tb_column_sync;

    localparam int NC = 30;
    localparam int DW = 18;
    localparam int TO = 1023;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_FIRE    = 2;
    localparam int P_ACK     = 3;
    localparam int P_ERR     = 4;

    logic          clk;
    logic          reset;
    logic          run;
    logic [NC-1:0] flags;
    logic [DW-1:0] u_mid;
    logic          start;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic [31:0]   step_count;
    logic [15:0]   step_cycles;
    logic          busy;
    logic          error;

    int            checks;
    int            failures;
    int            cyc;
    bit            rnd_ready;

    int            m_ph;
    int            m_entry;
    int            m_ack;
    logic [31:0]   m_steps;
    logic [15:0]   m_cycles;
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];

    column_sync #(.NUM_COLS(NC), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .flags        (flags),
        .u_mid        (u_mid),
        .start        (start),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .step_count   (step_count),
        .step_cycles  (step_cycles),
        .busy         (busy),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the effect of the coming edge, take it, compare.
    task automatic tick();
        logic all_done;
        logic all_clear;
        logic space;
        logic exp_start;
        int   v;
        if (rnd_ready) sample_ready = 1'($urandom_range(0, 1));
        all_done  = &flags;
        all_clear = (flags == '0);
        space     = (q.size() < 2);
        exp_start = 1'b0;
        if (q.size() > 0 && sample_ready) popped.push_back(q.pop_front());
        case (m_ph)
            P_IDLE: if (run) begin
                m_ph    = P_COLLECT;
                m_entry = cyc + 1;
            end
            P_COLLECT: if (!run) begin
                m_ph = P_IDLE;
            end else if (all_done && space) begin
                q.push_back(u_mid);
                v = cyc - m_entry;
                m_cycles  = (v > 65535) ? 16'hFFFF : 16'(v);
                m_ph      = P_FIRE;
                exp_start = 1'b1;
            end
            P_FIRE: begin
                m_ph  = P_ACK;
                m_ack = 0;
            end
            P_ACK: if (all_clear) begin
                m_steps = m_steps + 32'd1;
                m_ph    = P_COLLECT;
                m_entry = cyc + 1;
            end else if (m_ack == TO) begin
                m_ph = P_ERR;
            end else begin
                m_ack++;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        chk("start", 32'(start), 32'(exp_start));
        chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
        chk("error", 32'(error), 32'(m_ph == P_ERR));
        chk("step_count", step_count, m_steps);
        chk("step_cycles", 32'(step_cycles), 32'(m_cycles));
        chk("sample_valid", 32'(sample_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("sample_data", 32'(sample_data), 32'(q[0]));
    endtask

    task automatic wait_start(input int max);
        int n;
        n = 0;
        while (!start && n < max) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(start), 32'd1);
    endtask

    // Columns hold flags for 'hold' cycles after start, then clear them.
    task automatic ack_drop(input int hold);
        repeat (hold) tick();
        flags = '0;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        m_ph     = P_IDLE;
        m_steps  = 32'd0;
        m_cycles = 16'd0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rnd_ready = 1'b0;
        m_ph      = P_IDLE;
        m_entry   = 0;
        m_ack     = 0;
        m_steps   = 32'd0;
        m_cycles  = 16'd0;
        reset        = 1'b1;
        run          = 1'b0;
        flags        = '0;
        u_mid        = '0;
        sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_start", 32'(start), 32'd0);
        chk("init_valid", 32'(sample_valid), 32'd0);
        chk("init_data", 32'(sample_data), 32'd0);
        chk("init_steps", step_count, 32'd0);
        chk("init_cycles", 32'(step_cycles), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();

        // Basic step: flags 20 cycles after COLLECT entry, drop 2 after start.
        sample_ready = 1'b1;
        run = 1'b1;
        tick();
        repeat (20) tick();
        u_mid = 18'h04000;
        flags = '1;
        tick();
        chk("basic_start", 32'(start), 32'd1);
        chk("basic_cycles", 32'(step_cycles), 32'd20);
        chk("basic_data", 32'(sample_data), 32'h04000);
        tick();
        chk("basic_pulse_len", 32'(start), 32'd0);
        tick();
        flags = '0;
        tick();
        chk("basic_steps", step_count, 32'd1);

        // Partial flags: one column late holds off start.
        u_mid = 18'h1F000;
        flags = '1;
        flags[29] = 1'b0;
        repeat (500) tick();
        chk("partial_no_start", 32'(start), 32'd0);
        flags[29] = 1'b1;
        tick();
        chk("partial_start", 32'(start), 32'd1);
        ack_drop(1);

        // Backpressure: two queued, third withheld until a pop.
        repeat (3) tick();
        sample_ready = 1'b0;
        popped.delete();
        for (int v = 1; v <= 2; v++) begin
            u_mid = DW'(v);
            flags = '1;
            wait_start(10);
            ack_drop(1);
        end
        u_mid = 18'd3;
        flags = '1;
        repeat (30) tick();
        chk("bp_withheld", 32'(start), 32'd0);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        wait_start(5);
        ack_drop(1);
        sample_ready = 1'b1;
        repeat (5) tick();
        chk("bp_count", popped.size(), 32'd3);
        if (popped.size() == 3) begin
            chk("bp_order0", 32'(popped[0]), 32'd1);
            chk("bp_order1", 32'(popped[1]), 32'd2);
            chk("bp_order2", 32'(popped[2]), 32'd3);
        end

        // Randomized steps with random consumer stalls.
        rnd_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            repeat ($urandom_range(0, 15)) tick();
            u_mid = DW'($urandom());
            flags = '1;
            wait_start(300);
            ack_drop($urandom_range(0, 6));
        end
        rnd_ready = 1'b0;
        sample_ready = 1'b1;
        repeat (4) tick();

        // Run drop in COLLECT, then during ACK.
        run = 1'b0;
        tick();
        chk("rundrop_idle", 32'(busy), 32'd0);
        u_mid = 18'h2AAAA;
        flags = '1;
        repeat (5) tick();
        run = 1'b1;
        wait_start(5);
        run = 1'b0;
        ack_drop(1);
        chk("rundrop_ack_idle", 32'(busy), 32'd0);

        // Reset while in ACK with the FIFO full.
        sample_ready = 1'b0;
        run = 1'b1;
        u_mid = 18'd5;
        flags = '1;
        wait_start(5);
        ack_drop(0);
        u_mid = 18'd6;
        flags = '1;
        wait_start(5);
        tick();
        tick();
        chk("rst_fifo_valid", 32'(sample_valid), 32'd1);
        run = 1'b0;
        flags = '0;
        do_reset();
        tick();
        chk("rst_steps", step_count, 32'd0);

        // Ack timeout: column 0 never clears.
        sample_ready = 1'b1;
        run = 1'b1;
        u_mid = 18'd7;
        flags = '1;
        wait_start(10);
        flags = NC'(1);
        n = 0;
        while (!error && n < 1100) begin
            tick();
            n++;
        end
        chk("to_error", 32'(error), 32'd1);
        chk("to_cycles", n, 32'd1025);
        flags = '1;
        repeat (50) tick();
        chk("err_no_start", 32'(start), 32'd0);
        run = 1'b0;
        flags = '0;
        do_reset();
        tick();
        chk("err_cleared", 32'(error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
